button_conditioner: RTL and testbench

Synchronous front end for the calculator board's three push buttons. Raw pad levels are synchronised and debounced, and each button gets a clean level output on `push_out`, the bus the operand-entry stage uses for button events and the direction level. Button 2 can auto-repeat, so holding it produces a stream of fresh rising edges on `push_out[2]`. A one-cycle strobe per accepted press is also provided for clocked consumers.

---
 rtl/button_conditioner.sv | 109 ++++++++++
 tb/tb_button_conditioner.sv | 138 +++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and optionally auto-repeat push buttons
module button_conditioner #(
    parameter int               N_BTN         = 3,
    parameter int               DB_CYCLES     = 1_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = 3'b100,
    parameter int               REPEAT_DELAY  = 25_000_000,
    parameter int               REPEAT_PERIOD = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] push_out,
    output logic [N_BTN-1:0] push_pulse
);
    localparam int HMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = HMAX > 2 ? $clog2(HMAX) : 1;
    localparam int DW   = $clog2(DB_CYCLES);

    typedef enum logic [1:0] {LOW, HIGH, GAP} state_t;

    logic [N_BTN-1:0] s1, s, prev;

    // two-flop synchroniser; only s reaches the debouncers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s  <= '0;
        end else begin
            s1 <= btn_raw;
            s  <= s1;
        end
    end

    // strobe one cycle after each rising edge of push_out
    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= '0;
            push_pulse <= '0;
        end else begin
            prev       <= push_out;
            push_pulse <= push_out & ~prev;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        state_t        state, state_n;
        logic [DW-1:0] dcnt, dcnt_n;
        logic [HW-1:0] hcnt, hcnt_n;
        logic          first, first_n;
        logic          rel, hit;

        // channel state and counters
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= LOW;
                dcnt  <= '0;
                hcnt  <= '0;
                first <= 1'b0;
            end else begin
                state <= state_n;
                dcnt  <= dcnt_n;
                hcnt  <= hcnt_n;
                first <= first_n;
            end
        end

        // next state: debounce press/release, schedule repeat gaps; release beats a gap
        always_comb begin
            state_n = state;
            dcnt_n  = dcnt;
            hcnt_n  = hcnt;
            first_n = first;
            rel     = !s[g] && dcnt == DW'(DB_CYCLES - 1);
            hit     = REPEAT_MASK[g] &&
                      hcnt == (first ? HW'(REPEAT_DELAY - 1) : HW'(REPEAT_PERIOD - 1));
            case (state)
                LOW: begin
                    dcnt_n = s[g] ? dcnt + 1'b1 : '0;
                    if (s[g] && dcnt == DW'(DB_CYCLES - 1)) begin
                        state_n = HIGH;
                        dcnt_n  = '0;
                        hcnt_n  = '0;
                        first_n = 1'b1;
                    end
                end
                HIGH: begin
                    dcnt_n = s[g] ? '0 : dcnt + 1'b1;
                    if (REPEAT_MASK[g]) hcnt_n = hcnt + 1'b1;
                    if (rel) begin
                        state_n = LOW;
                        dcnt_n  = '0;
                        hcnt_n  = '0;
                    end else if (hit) begin
                        state_n = GAP;
                        hcnt_n  = '0;
                    end
                end
                GAP: begin
                    dcnt_n  = rel ? '0 : (s[g] ? '0 : dcnt + 1'b1);
                    first_n = 1'b0;
                    state_n = rel ? LOW : HIGH;
                end
                default: state_n = LOW;
            endcase
        end

        assign push_out[g] = state == HIGH;
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed plan steps plus random traffic against a run-length reference model
module tb_button_conditioner;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;
    localparam logic [2:0] MASK = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_raw = '0;
    logic [2:0] push_out, push_pulse;

    int checks = 0;
    int failures = 0;

    // reference model: delayed samples, accepted level, run of disagreeing samples, time since acceptance
    logic [2:0] d1, d2, acc, m_po, m_po_prev, m_pulse;
    int run [3];
    int held [3];

    button_conditioner #(
        .N_BTN(3), .DB_CYCLES(DB), .REPEAT_MASK(MASK),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .push_out(push_out), .push_pulse(push_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [2:0] raw);
        if (rst) begin
            d1 = '0; d2 = '0; acc = '0; m_po = '0; m_po_prev = '0; m_pulse = '0;
            for (int i = 0; i < 3; i++) begin run[i] = 0; held[i] = 0; end
        end else begin
            m_pulse   = m_po & ~m_po_prev;
            m_po_prev = m_po;
            for (int i = 0; i < 3; i++) begin
                if (d2[i] != acc[i]) run[i]++; else run[i] = 0;
                if (run[i] == DB) begin
                    acc[i] = d2[i]; run[i] = 0; held[i] = 0;
                end else held[i]++;
                m_po[i] = acc[i] && !(MASK[i] && held[i] >= RD && (held[i] - RD) % (RP + 1) == 0);
            end
            d2 = d1;
            d1 = raw;
        end
    endtask

    task automatic tick(input logic [2:0] raw);
        btn_raw = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        chk("model_push_out", push_out, m_po);
        chk("model_push_pulse", push_pulse, m_pulse);
    endtask

    initial begin
        logic [2:0] r;
        int b [5] = '{1, 0, 1, 1, 0};
        // reset with all buttons held
        rst = 1'b1;
        for (int k = 0; k < 3; k++) tick(3'b111);
        chk("reset_push_out", push_out, 3'b000);
        chk("reset_push_pulse", push_pulse, 3'b000);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick(3'b111);
            chk("rst_held_out", push_out, k >= 6 ? 3'b111 : 3'b000);
            chk("rst_held_pulse", push_pulse, k == 7 ? 3'b111 : 3'b000);
        end
        for (int k = 0; k < 8; k++) tick(3'b000);
        chk("all_released", push_out, 3'b000);
        // bouncing press on button 0
        for (int i = 0; i < 5; i++) begin
            tick(3'(b[i]));
            chk("bounce_out", push_out, 3'b000);
        end
        for (int k = 1; k <= 10; k++) begin
            tick(3'b001);
            chk("bounce_steady_out", push_out, k >= 6 ? 3'b001 : 3'b000);
            chk("bounce_steady_pulse", push_pulse, k == 7 ? 3'b001 : 3'b000);
        end
        for (int k = 0; k < 8; k++) tick(3'b000);
        // button 1 never repeats
        for (int k = 1; k <= 40; k++) begin
            tick(3'b010);
            chk("hold1_out", push_out, k >= 6 ? 3'b010 : 3'b000);
            chk("hold1_pulse", push_pulse, k == 7 ? 3'b010 : 3'b000);
        end
        for (int k = 0; k < 8; k++) tick(3'b000);
        // button 2 auto-repeat
        for (int k = 1; k <= 40; k++) begin
            tick(3'b100);
            chk("hold2_out", push_out,
                (k >= 6 && k != 16 && k != 22 && k != 28 && k != 34 && k != 40) ? 3'b100 : 3'b000);
            chk("hold2_pulse", push_pulse,
                (k == 7 || k == 18 || k == 24 || k == 30 || k == 36) ? 3'b100 : 3'b000);
        end
        // release confirms on the repeat-limit cycle: straight to LOW
        for (int k = 1; k <= 8; k++) begin
            tick(3'b000);
            chk("rel2_out", push_out, k <= 5 ? 3'b100 : 3'b000);
            chk("rel2_pulse", push_pulse, k == 2 ? 3'b100 : 3'b000);
        end
        // reset mid-repeat with button 2 held
        for (int k = 0; k < 20; k++) tick(3'b100);
        rst = 1'b1;
        tick(3'b100);
        chk("midrst_out", push_out, 3'b000);
        chk("midrst_pulse", push_pulse, 3'b000);
        rst = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick(3'b100);
            chk("reacc_out", push_out, (k >= 6 && k != 16) ? 3'b100 : 3'b000);
            chk("reacc_pulse", push_pulse, (k == 7 || k == 18) ? 3'b100 : 3'b000);
        end
        // random traffic with occasional resets
        r = 3'b100;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 3; i++) if ($urandom_range(7) == 0) r[i] = ~r[i];
            rst = $urandom_range(499) == 0;
            tick(r);
        end
        rst = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
